// File: rtl/game_flow_pkg.sv
// game_flow_pkg
//   Shared encodings for the breakout game sequencer: FSM state codes
//   (also driven onto state_dbg for the board LEDs) and the screen-select
//   codes that steer the rgb source mux in the design top.
package game_flow_pkg;

  localparam logic [2:0] ST_TITLE = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;
  localparam logic [2:0] ST_WIN   = 3'd5;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_GAME  = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;
  localparam logic [1:0] SCR_WIN   = 2'd3;

endpackage

// File: rtl/frame_timer.sv
// frame_timer
//   Counts frame ticks (falling edges of the registered vsync) and flags the
//   cycle in which the tick that reaches `target` arrives, so the owner can
//   change state on the following clock edge.
// Ports
//   clk, reset   clock / synchronous active-high reset
//   vsync        active-low vsync from the timing generator
//   clr          zero the counter (owner asserts it on every state change)
//   hold         freeze the counter; ticks during hold are dropped
//   target       number of ticks to count
//   done         1 in the cycle of the target-th tick (combinational)
module frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             clr,
  input  logic             hold,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  logic             vsync_q, vsync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // vsync idles high, so resetting the history to 1 avoids a fake tick.
  assign vsync_d = vsync;
  assign tick    = vsync_q & ~vsync;
  assign done    = tick & ~hold & (cnt_q == target - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (tick && !hold && cnt_q != target)
      cnt_d = cnt_q + CNT_W'(1);   // saturates at target
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      vsync_q <= vsync_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Game-level sequencer for the VGA breakout design: tracks lives/level,
//   gates breakout motion, times the serve delay and end screens off frame
//   ticks and selects the screen source.
// Build option
//   GAME_FLOW_PAUSE_EN  adds the PAUSE state toggled by key_pause; without it
//                       key_pause is ignored.
// Ports
//   clk, reset          pixel clock / synchronous active-high reset
//   key_start/key_pause 1-cycle key pulses
//   vsync               active-low vsync (falling edge = frame tick)
//   ball_lost           1-cycle pulse: ball passed the paddle
//   bricks_clear        1-cycle pulse: last brick destroyed
//   game_run            high only in PLAY
//   game_rst            1-cycle pulse: re-init bricks and ball
//   serve               1-cycle pulse on SERVE->PLAY
//   scr_sel             0 title, 1 game, 2 game over, 3 win
//   lives, level        remaining lives / current level (1-based)
//   state_dbg           current state encoding
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int LEVEL_MAX    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int END_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       vsync,
  input  logic       ball_lost,
  input  logic       bricks_clear,
  output logic       game_run,
  output logic       game_rst,
  output logic       serve,
  output logic [1:0] scr_sel,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic [2:0] state_dbg
);

  localparam int FT_MAX = (SERVE_FRAMES > END_FRAMES) ? SERVE_FRAMES : END_FRAMES;
  localparam int CNT_W  = $clog2(FT_MAX + 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       lives_q, lives_d;
  logic [3:0]       level_q, level_d;
  logic             game_rst_q, game_rst_d;
  logic             serve_q, serve_d;

  logic             ft_clr, ft_hold, ft_done;
  logic [CNT_W-1:0] ft_target;

  // Only SERVE and OVER/WIN consume done; END_FRAMES is a harmless target
  // for the other states since the counter saturates.
  assign ft_target = (state_q == ST_SERVE) ? CNT_W'(SERVE_FRAMES) : CNT_W'(END_FRAMES);
  assign ft_clr    = (state_d != state_q);

`ifdef GAME_FLOW_PAUSE_EN
  assign ft_hold = (state_q == ST_PAUSE);
`else
  logic unused_key_pause;
  assign unused_key_pause = key_pause;
  assign ft_hold = 1'b0;
`endif

  frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .vsync  (vsync),
    .clr    (ft_clr),
    .hold   (ft_hold),
    .target (ft_target),
    .done   (ft_done)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    game_rst_d = 1'b0;
    serve_d    = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (key_start) begin
          state_d    = ST_SERVE;
          lives_d    = 3'(LIVES_INIT);
          level_d    = 4'd1;
          game_rst_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (ft_done) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // bricks_clear wins over ball_lost, so a simultaneous loss costs no life.
        if (bricks_clear) begin
          if (level_q >= 4'(LEVEL_MAX)) begin
            state_d = ST_WIN;
          end else begin
            level_d    = level_q + 4'd1;
            game_rst_d = 1'b1;
            state_d    = ST_SERVE;
          end
        end else if (ball_lost) begin
          if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = ST_OVER;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = ST_SERVE;
          end
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (key_pause) begin
          state_d = ST_PAUSE;
        end
`endif
      end
`ifdef GAME_FLOW_PAUSE_EN
      ST_PAUSE: begin
        if (key_pause) state_d = ST_PLAY;
      end
`endif
      ST_OVER, ST_WIN: begin
        if (key_start || ft_done) state_d = ST_TITLE;
      end
      default: state_d = ST_TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_TITLE;
      lives_q    <= 3'd0;
      level_q    <= 4'd0;
      game_rst_q <= 1'b0;
      serve_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      game_rst_q <= game_rst_d;
      serve_q    <= serve_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_SERVE, ST_PLAY, ST_PAUSE: scr_sel = SCR_GAME;
      ST_OVER:                     scr_sel = SCR_OVER;
      ST_WIN:                      scr_sel = SCR_WIN;
      default:                     scr_sel = SCR_TITLE;
    endcase
  end

  assign game_run  = (state_q == ST_PLAY);
  assign game_rst  = game_rst_q;
  assign serve     = serve_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign state_dbg = state_q;

endmodule
